// File: rtl/led_pattern_ctrl.sv
// LED pattern controller.
// A free-running prescaler produces a 1 ms tick. A millisecond counter turns
// that tick into a programmable step period. A four-mode FSM, advanced by a
// debounced key pulse, selects what each step does to the LED vector.
module led_pattern_ctrl #(
  parameter int TICK_CYC = 50_000,
  parameter int LED_NUM  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_pulse,
  input  logic [15:0]        period_ms,
  output logic [LED_NUM-1:0] led,
  output logic [1:0]         mode,
  output logic               tick_ms
);

  localparam int              PW        = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_CYC - 1);
  localparam logic [LED_NUM-1:0] LED_LSB = {{(LED_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    RUN   = 2'd2,
    FLOW  = 2'd3
  } mode_t;

  mode_t              state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [15:0]        ms_cnt_q, ms_cnt_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               tick_int;
  logic               step;
  logic [15:0]        period_eff;

  // A period of 0 would never wrap sensibly, so it behaves as 1 ms.
  function automatic logic [15:0] eff_period(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

  // Mode sequence advanced by each key pulse.
  function automatic mode_t next_mode(input mode_t m);
    mode_t r;
    case (m)
      IDLE:    r = BLINK;
      BLINK:   r = RUN;
      RUN:     r = FLOW;
      default: r = IDLE;
    endcase
    return r;
  endfunction

  // LED value loaded when a mode is entered.
  function automatic logic [LED_NUM-1:0] entry_led(input mode_t m);
    logic [LED_NUM-1:0] r;
    case (m)
      IDLE:    r = '0;
      BLINK:   r = '1;
      default: r = LED_LSB;
    endcase
    return r;
  endfunction

  // LED update applied on each step of the current mode.
  function automatic logic [LED_NUM-1:0] step_led(input mode_t m,
                                                  input logic [LED_NUM-1:0] cur);
    logic [LED_NUM-1:0] r;
    case (m)
      IDLE:    r = '0;
      BLINK:   r = ~cur;
      RUN:     r = {cur[LED_NUM-2:0], cur[LED_NUM-1]};
      default: begin
        // Fill from the LSB up, blank once full, then restart from one LED.
        if (&cur)
          r = '0;
        else if (cur == '0)
          r = LED_LSB;
        else
          r = {cur[LED_NUM-2:0], 1'b1};
      end
    endcase
    return r;
  endfunction

  assign tick_int   = (presc_q == PRESC_MAX);
  assign period_eff = eff_period(period_ms);

  // Next-state logic: prescaler, ms counter, mode and LED pattern.
  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    presc_d  = tick_int ? '0 : presc_q + 1'b1;
    ms_cnt_d = ms_cnt_q;
    step     = 1'b0;

    // The >= compare lets a shortened period wrap on the next tick instead
    // of running the counter all the way round.
    if (tick_int) begin
      if (ms_cnt_q >= period_eff - 16'd1) begin
        ms_cnt_d = '0;
        step     = 1'b1;
      end else begin
        ms_cnt_d = ms_cnt_q + 16'd1;
      end
    end

    // A key pulse overrides a coincident step and restarts the timebase so
    // the first step in the new mode lands a full period later.
    if (key_pulse) begin
      state_d  = next_mode(state_q);
      led_d    = entry_led(state_d);
      presc_d  = '0;
      ms_cnt_d = '0;
    end else if (step) begin
      led_d    = step_led(state_q, led_q);
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      led_q    <= '0;
      presc_q  <= '0;
      ms_cnt_q <= '0;
      tick_ms  <= 1'b0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      presc_q  <= presc_d;
      ms_cnt_q <= ms_cnt_d;
      tick_ms  <= tick_int;
    end
  end

  assign led  = led_q;
  assign mode = state_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed testbench for led_pattern_ctrl with a 10-cycle ms tick.
module tb_led_pattern_ctrl;

  localparam int TICK_CYC = 10;
  localparam int LED_NUM  = 4;

  logic               clk;
  logic               rst_n;
  logic               key_pulse;
  logic [15:0]        period_ms;
  logic [LED_NUM-1:0] led;
  logic [1:0]         mode;
  logic               tick_ms;

  int n_checks;
  int n_errors;

  led_pattern_ctrl #(
    .TICK_CYC(TICK_CYC),
    .LED_NUM (LED_NUM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_pulse(key_pulse),
    .period_ms(period_ms),
    .led      (led),
    .mode     (mode),
    .tick_ms  (tick_ms)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic advance(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Single-cycle key pulse; returns at the negedge after the key edge.
  task automatic press_key();
    key_pulse = 1'b1;
    @(negedge clk);
    key_pulse = 1'b0;
  endtask

  task automatic check_led(input string tag, input logic [3:0] exp_v);
    check_eq(tag, 32'(led), 32'(exp_v));
  endtask

  logic [3:0] run_seq  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] flow_seq [7] = '{4'b0011, 4'b0111, 4'b1111, 4'b0000,
                               4'b0001, 4'b0011, 4'b0111};

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    key_pulse = 1'b0;
    period_ms = 16'd3;

    // Reset state
    advance(3);
    check_led("reset_led", 4'b0000);
    check_eq("reset_mode", 32'(mode), 32'd0);
    check_eq("reset_tick", 32'(tick_ms), 32'd0);

    // IDLE: tick every 10 clocks, LEDs dark
    rst_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      check_eq("idle_tick", 32'(tick_ms), (i % 10 == 0) ? 32'd1 : 32'd0);
      check_led("idle_led", 4'b0000);
    end
    check_eq("idle_mode", 32'(mode), 32'd0);

    // BLINK
    press_key();
    check_eq("blink_mode", 32'(mode), 32'd1);
    check_led("blink_entry", 4'b1111);
    advance(29); check_led("blink_hold0", 4'b1111);
    advance(1);  check_led("blink_step1", 4'b0000);
    advance(29); check_led("blink_hold1", 4'b0000);
    advance(1);  check_led("blink_step2", 4'b1111);

    // RUN
    advance(40);
    press_key();
    check_eq("run_mode", 32'(mode), 32'd2);
    check_led("run_entry", 4'b0001);
    for (int i = 0; i < 4; i++) begin
      advance(29); check_led("run_hold", (i == 0) ? 4'b0001 : run_seq[i-1]);
      advance(1);  check_led("run_step", run_seq[i]);
    end

    // Key coincident with a RUN step: key wins, FLOW entry, no rotate
    advance(29);
    check_led("run_prekey", 4'b0001);
    press_key();
    check_eq("flow_mode", 32'(mode), 32'd3);
    check_led("flow_entry", 4'b0001);
    for (int i = 0; i < 7; i++) begin
      advance(29); check_led("flow_hold", (i == 0) ? 4'b0001 : flow_seq[i-1]);
      advance(1);  check_led("flow_step", flow_seq[i]);
    end

    // Asynchronous reset mid-cycle while in FLOW with 0111
    #2 rst_n = 1'b0;
    #1;
    check_led("async_led", 4'b0000);
    check_eq("async_mode", 32'(mode), 32'd0);
    check_eq("async_tick", 32'(tick_ms), 32'd0);
    advance(2);
    rst_n = 1'b1;
    advance(9);  check_eq("resume_tick0", 32'(tick_ms), 32'd0);
    advance(1);  check_eq("resume_tick1", 32'(tick_ms), 32'd1);

    // Key held 3 cycles advances three modes
    key_pulse = 1'b1;
    advance(3);
    key_pulse = 1'b0;
    check_eq("hold_mode", 32'(mode), 32'd3);
    check_led("hold_led", 4'b0001);

    // FLOW -> IDLE
    advance(5);
    press_key();
    check_eq("wrap_mode", 32'(mode), 32'd0);
    check_led("wrap_led", 4'b0000);

    // period_ms = 0 behaves as 1: BLINK steps every 10 clocks
    period_ms = 16'd0;
    advance(5);
    press_key();
    check_eq("p0_mode", 32'(mode), 32'd1);
    check_led("p0_entry", 4'b1111);
    advance(9);  check_led("p0_hold", 4'b1111);
    advance(1);  check_led("p0_step1", 4'b0000);
    advance(10); check_led("p0_step2", 4'b1111);

    // ms_cnt reaches 3 under period 10, then period 5: one more increment
    // to 4, then the following tick steps
    period_ms = 16'd10;
    advance(30);
    period_ms = 16'd5;
    advance(19); check_led("p5_hold", 4'b1111);
    advance(1);  check_led("p5_step", 4'b0000);

    // ms_cnt reaches 4 under period 10, then period 2: next tick steps
    period_ms = 16'd10;
    advance(40);
    period_ms = 16'd2;
    advance(9);  check_led("p2_hold", 4'b0000);
    advance(1);  check_led("p2_step", 4'b1111);
    advance(19); check_led("p2_hold2", 4'b1111);
    advance(1);  check_led("p2_step2", 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
